// File: rtl/vrf_rd_sequencer.sv
// Operand-fetch sequencer for the banked vector register file: walks a vector
// operation row by row, alternating src1/src2 row reads under a ready handshake.
module vrf_rd_sequencer #(
    parameter int NUM_BANKS = 8,
    parameter int ADDR_W    = 7,
    parameter int VLEN_W    = 10
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    src1_start_addr,
    input  logic [ADDR_W-1:0]    src2_start_addr,
    input  logic [VLEN_W-1:0]    vec_length,
    input  logic                 flush,
    input  logic                 op_ready,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    output logic [NUM_BANKS-1:0] rd_bank_mask,
    output logic                 rd_sel,
    output logic                 rd_last,
    output logic                 busy,
    output logic                 done
);

    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = VLEN_W - BANK_W + 1;
    localparam logic [NUM_BANKS-1:0] ALL_BANKS = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_S1 = 2'd1,
        RD_S2 = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ROW_W-1:0]    rows_q, rows_d;
    logic [ADDR_W-1:0]   src1_q, src1_d;
    logic [ADDR_W-1:0]   src2_q, src2_d;
    logic [BANK_W-1:0]   rem_q, rem_d;

    logic [ROW_W-1:0]     rows_calc;
    logic                 last_row;
    logic [NUM_BANKS-1:0] row_mask;

    // Row count is ceil(len / NUM_BANKS); a partial tail row adds one.
    assign rows_calc = ROW_W'(vec_length >> BANK_W) + ROW_W'(|vec_length[BANK_W-1:0]);
    assign last_row  = (row_q == rows_q - ROW_W'(1));
    assign row_mask  = (last_row && (rem_q != '0)) ? ~(ALL_BANKS << rem_q) : ALL_BANKS;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            row_q   <= '0;
            rows_q  <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            rows_q  <= rows_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        rows_d  = rows_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src1_d  = src1_start_addr;
                    src2_d  = src2_start_addr;
                    rem_d   = vec_length[BANK_W-1:0];
                    rows_d  = rows_calc;
                    row_d   = '0;
                    state_d = (vec_length == '0) ? DONE : RD_S1;
                end
            end
            RD_S1: begin
                if (op_ready) state_d = RD_S2;
            end
            RD_S2: begin
                if (op_ready) begin
                    if (last_row) begin
                        state_d = DONE;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = RD_S1;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over every transition, including a start seen in IDLE.
        if (flush) state_d = IDLE;
    end

    always_comb begin
        rd_en        = 1'b0;
        rd_sel       = 1'b0;
        rd_addr      = '0;
        rd_bank_mask = '0;
        rd_last      = 1'b0;
        busy         = (state_q != IDLE);
        done         = (state_q == DONE);
        unique case (state_q)
            RD_S1: begin
                rd_en        = 1'b1;
                rd_addr      = src1_q + ADDR_W'(row_q);
                rd_bank_mask = row_mask;
            end
            RD_S2: begin
                rd_en        = 1'b1;
                rd_sel       = 1'b1;
                rd_addr      = src2_q + ADDR_W'(row_q);
                rd_bank_mask = row_mask;
                rd_last      = last_row;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vrf_rd_sequencer.sv
// Self-checking bench for vrf_rd_sequencer: a transaction-level model builds the
// expected list of row reads per command and is stepped in lockstep with the DUT.
module tb_vrf_rd_sequencer;

    localparam int NB = 8;
    localparam int AW = 7;
    localparam int VW = 10;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic [AW-1:0] src1;
    logic [AW-1:0] src2;
    logic [VW-1:0] vlen;
    logic          flush;
    logic          op_ready;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [NB-1:0] rd_bank_mask;
    logic          rd_sel;
    logic          rd_last;
    logic          busy;
    logic          done;

    vrf_rd_sequencer #(.NUM_BANKS(NB), .ADDR_W(AW), .VLEN_W(VW)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .src1_start_addr (src1),
        .src2_start_addr (src2),
        .vec_length      (vlen),
        .flush           (flush),
        .op_ready        (op_ready),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_bank_mask    (rd_bank_mask),
        .rd_sel          (rd_sel),
        .rd_last         (rd_last),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          sel;
        logic [AW-1:0] addr;
        logic [NB-1:0] mask;
        logic          last;
    } issue_t;

    issue_t exp_q[$];
    int     phase;       // 0 = idle, 1 = reads outstanding, 2 = completion cycle
    int     vectors = 0;
    int     errors  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic void buildIssues(input int s1, input int s2, input int len);
        int rows = (len + NB - 1) / NB;
        int rem  = len % NB;
        exp_q.delete();
        for (int r = 0; r < rows; r++) begin
            issue_t it;
            it.mask = (r == rows - 1 && rem != 0) ? NB'((1 << rem) - 1) : NB'((1 << NB) - 1);
            it.sel  = 1'b0;
            it.addr = AW'((s1 + r) % (1 << AW));
            it.last = 1'b0;
            exp_q.push_back(it);
            it.sel  = 1'b1;
            it.addr = AW'((s2 + r) % (1 << AW));
            it.last = (r == rows - 1);
            exp_q.push_back(it);
        end
    endfunction

    task automatic checkCycle();
        checkOutput("rd_en", rd_en, phase == 1);
        checkOutput("busy",  busy,  phase != 0);
        checkOutput("done",  done,  phase == 2);
        if (phase == 1) begin
            checkOutput("rd_sel",  rd_sel,       exp_q[0].sel);
            checkOutput("rd_addr", rd_addr,      exp_q[0].addr);
            checkOutput("mask",    rd_bank_mask, exp_q[0].mask);
            checkOutput("rd_last", rd_last,      exp_q[0].last);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rd_en"}, rd_en, 0);
        checkOutput({tag, "_addr"},  rd_addr, 0);
        checkOutput({tag, "_mask"},  rd_bank_mask, 0);
        checkOutput({tag, "_sel"},   rd_sel, 0);
        checkOutput({tag, "_last"},  rd_last, 0);
        checkOutput({tag, "_busy"},  busy, 0);
        checkOutput({tag, "_done"},  done, 0);
    endtask

    task automatic modelAdvance();
        if (flush) begin
            phase = 0;
            exp_q.delete();
        end else begin
            case (phase)
                0: if (start) begin
                    buildIssues(src1, src2, vlen);
                    phase = (vlen == 0) ? 2 : 1;
                end
                1: if (op_ready) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) phase = 2;
                end
                default: phase = 0;
            endcase
        end
    endtask

    // One command: start in cycle 0, then random ready / ignored starts until idle.
    task automatic applyStimulus(input int s1, input int s2, input int len, input int ready_pct,
                                 input int stall_at, input int flush_at, input int rst_at,
                                 input int exp_done);
        int done_seen = -1;
        for (int c = 0; c < 4000; c++) begin
            if (c == 0) begin
                start = 1'b1;
                src1  = AW'(s1);
                src2  = AW'(s2);
                vlen  = VW'(len);
            end else begin
                start = ($urandom_range(0, 3) == 0);
                src1  = AW'($urandom);
                src2  = AW'($urandom);
                vlen  = VW'($urandom);
            end
            flush    = (c == flush_at);
            op_ready = (stall_at >= 0 && c >= stall_at && c < stall_at + 3) ? 1'b0 :
                       ($urandom_range(1, 100) <= ready_pct);
            if (c == rst_at) begin
                rstn = 1'b0;
                #1;
                checkAllZero("async_rst");
                exp_q.delete();
                phase = 0;
                start = 1'b0;
                flush = 1'b0;
                @(negedge clk);
                checkAllZero("in_rst");
                rstn = 1'b1;
                @(posedge clk);
                #1;
                return;
            end
            @(negedge clk);
            checkCycle();
            if (done) done_seen = c;
            modelAdvance();
            @(posedge clk);
            #1;
            if (phase == 0) break;
        end
        start    = 1'b0;
        flush    = 1'b0;
        op_ready = 1'b0;
        @(negedge clk);
        checkCycle();
        @(posedge clk);
        #1;
        if (exp_done >= 0) checkOutput("done_cycle", done_seen, exp_done);
    endtask

    initial begin
        rstn     = 1'b1;
        start    = 1'b0;
        flush    = 1'b0;
        op_ready = 1'b0;
        src1     = '0;
        src2     = '0;
        vlen     = '0;
        phase    = 0;
        #1 rstn  = 1'b0;
        #20;
        checkAllZero("reset");
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed scenarios");
        applyStimulus(4,   20,  16, 100, -1, -1, -1, 5);
        applyStimulus(0,   8,   13, 100, -1, -1, -1, 5);
        applyStimulus(9,   9,   0,  100, -1, -1, -1, 1);
        applyStimulus(127, 126, 24, 100, -1, -1, -1, 7);
        applyStimulus(33,  70,  8,  100, 2,  -1, -1, 6);
        applyStimulus(5,   50,  16, 100, -1, 3,  -1, -1);
        applyStimulus(5,   50,  16, 100, -1, 0,  -1, -1);
        applyStimulus(10,  100, 40, 100, -1, -1, 5,  -1);
        applyStimulus(3,   50,  40, 100, -1, -1, -1, 11);

        $display("[TB] randomized commands");
        for (int n = 0; n < 40; n++) begin
            int len    = (n % 5 == 4) ? $urandom_range(0, 1023) : $urandom_range(0, 64);
            int rdy    = $urandom_range(30, 100);
            int fl     = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 12) : -1;
            applyStimulus($urandom_range(0, 127), $urandom_range(0, 127), len, rdy, -1, fl, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
